// File: rtl/monociclo_pkg.sv
// Shared datapath widths, writeback request type and register scoreboard helpers.
package monociclo_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned RIDX_W = $clog2(NREGS);

    typedef struct packed {
        logic              valid;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef logic [NREGS-1:0] busy_vec_t;

    // A same-cycle B write to idx is forwarded by RegistersUnit, so it no longer counts as busy.
    function automatic logic busy_hit(input busy_vec_t busy, input logic [RIDX_W-1:0] idx,
                                      input logic clr_en, input logic [RIDX_W-1:0] clr_idx);
        return (idx != '0) && busy[idx] && !(clr_en && (clr_idx == idx));
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding long-latency results, with hazard lookup on three indices.
module regfile_scoreboard
    import monociclo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [RIDX_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [RIDX_W-1:0] clr_idx_i,
    input  logic [RIDX_W-1:0] rs1_i,
    input  logic [RIDX_W-1:0] rs2_i,
    input  logic [RIDX_W-1:0] rd_i,
    output logic              hit_rs1_o,
    output logic              hit_rs2_o,
    output logic              hit_rd_o,
    output logic              clr_busy_o
);

    busy_vec_t busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        // Set is applied after clear so a new issue to the same register wins.
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hit_rs1_o  = busy_hit(busy_q, rs1_i, clr_en_i, clr_idx_i);
    assign hit_rs2_o  = busy_hit(busy_q, rs2_i, clr_en_i, clr_idx_i);
    assign hit_rd_o   = busy_hit(busy_q, rd_i, clr_en_i, clr_idx_i);
    assign clr_busy_o = busy_q[clr_idx_i];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the RegistersUnit write port between the ALU and the long-latency unit,
// and stalls issue on hazards against outstanding long-latency results.
module regfile_wb_scheduler
    import monociclo_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IssueValid,
    input  logic              IssueLL,
    input  logic [RIDX_W-1:0] IssueRs1,
    input  logic [RIDX_W-1:0] IssueRs2,
    input  logic [RIDX_W-1:0] IssueRd,
    output logic              IssueStall,
    input  logic              WbAValid,
    input  logic [RIDX_W-1:0] WbARd,
    input  logic [XLEN-1:0]   WbAData,
    input  logic              WbBValid,
    input  logic [RIDX_W-1:0] WbBRd,
    input  logic [XLEN-1:0]   WbBData,
    output logic              WbBReady,
    output logic              PipeHold,
    output logic              RUWr,
    output logic [RIDX_W-1:0] Rd,
    output logic [XLEN-1:0]   DataWr,
    output logic              ErrSpurious
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    wb_req_t         req_a, req_b;
    logic            grant_a, grant_b;
    logic [CntW-1:0] starve_q, starve_d;
    logic            err_q;
    logic            hit_rs1, hit_rs2, hit_rd, clr_busy;
    logic            set_en;

    assign req_a = '{valid: WbAValid, rd: WbARd, data: WbAData};
    assign req_b = '{valid: WbBValid, rd: WbBRd, data: WbBData};

    always_comb begin
        PipeHold = (starve_q == CntW'(STARVE_LIMIT));
        grant_b  = req_b.valid && (!req_a.valid || PipeHold);
        grant_a  = req_a.valid && !grant_b;
        Rd       = '0;
        DataWr   = '0;
        if (grant_b) begin
            Rd     = req_b.rd;
            DataWr = req_b.data;
        end else if (grant_a) begin
            Rd     = req_a.rd;
            DataWr = req_a.data;
        end
        RUWr     = (grant_a || grant_b) && (Rd != '0);
        WbBReady = grant_b;
    end

    always_comb begin
        starve_d = '0;
        if (WbBValid && !WbBReady) begin
            starve_d = PipeHold ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            if (WbBReady && (WbBRd != '0) && !clr_busy) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ErrSpurious = err_q;
    assign IssueStall  = IssueValid && (hit_rs1 || hit_rs2 || hit_rd);
    assign set_en      = IssueValid && !IssueStall && IssueLL && (IssueRd != '0);

    regfile_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (set_en),
        .set_idx_i  (IssueRd),
        .clr_en_i   (WbBReady),
        .clr_idx_i  (WbBRd),
        .rs1_i      (IssueRs1),
        .rs2_i      (IssueRs2),
        .rd_i       (IssueRd),
        .hit_rs1_o  (hit_rs1),
        .hit_rs2_o  (hit_rs2),
        .hit_rd_o   (hit_rd),
        .clr_busy_o (clr_busy)
    );

    // The ALU pipeline must not present a result while PipeHold is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(WbAValid && PipeHold));
        end
    end

endmodule
